// File: rtl/cyborg65r2_phase_gen_pkg.sv
// Shared constants, FSM encoding and the ring fine-pattern helper for the phase generator.
// The fine pattern is the de-inverted thermometer word the CCO ring presents at state s.
package cyborg65r2_pkg;
  localparam int NPHASES     = 33;
  localparam int CNT_W       = 6;
  localparam int FCW_W       = 15;
  localparam int RING_STATES = 2 * NPHASES;
  localparam int PB_W        = 12;

  localparam logic [NPHASES-1:0] FINE_INV_MASK = 33'h0AAAAAAAA;
  localparam logic [FCW_W-1:0]   FCW_RESET     = 15'h0100;
  localparam logic [6:0]         INT_MAX       = 7'd65;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // First half of the ring fills ones from bit 0, second half drains them from bit 0.
  function automatic logic [NPHASES-1:0] fine_pattern(input logic [6:0] s);
    logic [NPHASES-1:0] d;
    d = '0;
    for (int i = 0; i < NPHASES; i++) begin
      if (s <= 7'(NPHASES)) d[i] = (i < int'(s));
      else                  d[i] = (i >= int'(s) - NPHASES);
    end
    return d;
  endfunction
endpackage

// File: rtl/cyborg65r2_phase_gen_if.sv
// Command, fcw handshake and raw front-end output bundle of the phase generator.
interface cyborg65r2_phase_gen_if;
  import cyborg65r2_pkg::*;

  logic               start;
  logic               stop;
  logic               step;
  logic               clear;
  logic               inject_stale;
  logic [FCW_W-1:0]   fcw;
  logic               fcw_valid;
  logic               fcw_ready;
  logic [CNT_W-1:0]   count_coarse;
  logic [CNT_W-1:0]   count_coarse_del;
  logic [NPHASES-1:0] count_fine;
  logic [PB_W-1:0]    phase_bin;
  logic               out_valid;

  modport master (
    output start, stop, step, clear, inject_stale, fcw, fcw_valid,
    input  fcw_ready, count_coarse, count_coarse_del, count_fine, phase_bin, out_valid
  );

  modport slave (
    input  start, stop, step, clear, inject_stale, fcw, fcw_valid,
    output fcw_ready, count_coarse, count_coarse_del, count_fine, phase_bin, out_valid
  );
endinterface

// File: rtl/cyborg65r2_phase_gen_bin2gray.sv
// Binary to reflected Gray code converter; inverse of gray2bin.
module bin2gray #(
  parameter int bus_width = 6
) (
  input  logic [bus_width-1:0] bin_i,
  output logic [bus_width-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/cyborg65r2_phase_gen.sv
// Digital CCO emulator: advances a 66x64 ring phase by a 7.8 fcw and drives raw Gray/fine words.
// Outputs are registered one cycle after the advance decision; fcw_ready drops for one cycle after each accept.
module cyborg65r2_phase_gen
  import cyborg65r2_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  cyborg65r2_phase_gen_if.slave bus_io
);
  state_e             state_q, state_d;
  logic [6:0]         s_q, s_d;
  logic [CNT_W-1:0]   c_q, c_d, c_dm1;
  logic [7:0]         frac_q, frac_d;
  logic [PB_W-1:0]    pb_q, pb_d;
  logic [FCW_W-1:0]   fcw_q;
  logic               fcw_rdy_q;
  logic               vld_q;
  logic [NPHASES-1:0] fine_q;
  logic [CNT_W-1:0]   cc_q, cd_q;

  logic               adv, clr, fcw_take, stale;
  logic [8:0]         frac_sum;
  logic [6:0]         int_sat, inc;
  logic [7:0]         t;
  logic [NPHASES-1:0] d_nxt;
  logic [CNT_W-1:0]   gray_c, gray_cm1;

  // In HOLD a stop request outranks every other command and simply keeps HOLD.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (bus_io.start) state_d = ST_RUN;
      ST_RUN: begin
        adv = 1'b1;
        if (bus_io.stop) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus_io.stop) begin
          if (bus_io.clear) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
          end else if (bus_io.start) begin
            state_d = ST_RUN;
          end else if (bus_io.step) begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frac_sum = {1'b0, frac_q} + {1'b0, fcw_q[7:0]};
    int_sat  = (fcw_q[FCW_W-1:8] > INT_MAX) ? INT_MAX : fcw_q[FCW_W-1:8];
    inc      = int_sat + {6'd0, frac_sum[8]};
    t        = {1'b0, s_q} + {1'b0, inc};
    s_d      = s_q;
    c_d      = c_q;
    frac_d   = frac_q;
    pb_d     = pb_q;
    if (adv) begin
      frac_d = frac_sum[7:0];
      pb_d   = pb_q + {5'd0, inc};
      // inc never exceeds 66, so a single wrap of the ring is enough.
      if (t >= 8'(RING_STATES)) begin
        s_d = 7'(t - 8'(RING_STATES));
        c_d = c_q + 6'd1;
      end else begin
        s_d = t[6:0];
      end
    end
    if (clr) begin
      s_d    = '0;
      c_d    = '0;
      frac_d = '0;
      pb_d   = '0;
    end
  end

  assign c_dm1    = c_d - 6'd1;
  assign d_nxt    = fine_pattern(s_d);
  // Stale window is exactly where the encoder switches to the delayed coarse value.
  assign stale    = bus_io.inject_stale & (d_nxt[0] | d_nxt[6]);
  assign fcw_take = bus_io.fcw_valid & fcw_rdy_q;

  bin2gray #(.bus_width(CNT_W)) u_gray_c   (.bin_i(c_d),   .gray_o(gray_c));
  bin2gray #(.bus_width(CNT_W)) u_gray_cm1 (.bin_i(c_dm1), .gray_o(gray_cm1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      c_q       <= '0;
      frac_q    <= '0;
      pb_q      <= '0;
      fcw_q     <= FCW_RESET;
      fcw_rdy_q <= 1'b1;
      vld_q     <= 1'b0;
      fine_q    <= FINE_INV_MASK;
      cc_q      <= '0;
      cd_q      <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      frac_q    <= frac_d;
      pb_q      <= pb_d;
      fcw_rdy_q <= ~fcw_take;
      if (fcw_take) fcw_q <= bus_io.fcw;
      vld_q     <= adv;
      fine_q    <= d_nxt ^ FINE_INV_MASK;
      cc_q      <= stale ? gray_cm1 : gray_c;
      cd_q      <= gray_c;
    end
  end

  assign bus_io.fcw_ready        = fcw_rdy_q;
  assign bus_io.out_valid        = vld_q;
  assign bus_io.count_fine       = fine_q;
  assign bus_io.count_coarse     = cc_q;
  assign bus_io.count_coarse_del = cd_q;
  assign bus_io.phase_bin        = pb_q;
endmodule

// File: tb/tb_cyborg65r2_phase_gen.sv
// Bench for cyborg65r2_phase_gen: behavioural model feeding a scoreboard queue, a vector table
// of long runs with hand-computed end states, and short sequences for stale, HOLD and reset cases.
module tb_cyborg65r2_phase_gen;
  import cyborg65r2_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cyborg65r2_phase_gen_if bus ();
  cyborg65r2_phase_gen dut (.clk(clk), .reset(reset), .bus_io(bus));

  typedef struct {
    logic [5:0]  cc;
    logic [5:0]  cd;
    logic [32:0] fine;
    logic [11:0] pb;
  } obs_t;

  typedef struct {
    logic [14:0] fcw;
    int          nadv;
    logic [11:0] pb;
    logic [5:0]  cd;
    logic [32:0] fine;
  } vec_t;

  obs_t sb[$];
  vec_t vt[7];
  int   checks = 0;
  int   errors = 0;

  int m_state, m_s, m_c, m_frac, m_pb, m_fcw;
  bit m_rdy;

  function automatic logic [32:0] m_fine(input int s);
    logic [33:0] d;
    if (s <= 33) d = (34'd1 << s) - 34'd1;
    else         d = ~((34'd1 << (s - 33)) - 34'd1);
    return d[32:0] ^ 33'h0AAAAAAAA;
  endfunction

  function automatic logic [5:0] m_gray(input int b);
    logic [5:0] v;
    v = 6'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic obs_t m_obs(input bit inj);
    obs_t        o;
    logic [32:0] d;
    d      = m_fine(m_s) ^ 33'h0AAAAAAAA;
    o.cd   = m_gray(m_c);
    o.cc   = (inj && (d[0] || d[6])) ? m_gray((m_c + 63) % 64) : o.cd;
    o.fine = m_fine(m_s);
    o.pb   = 12'(m_pb);
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from the driven inputs, push the expected advance, then compare.
  task automatic tick();
    bit   adv;
    bit   inj;
    int   cy, inc;
    obs_t e;
    adv = 1'b0;
    inj = bus.inject_stale;
    if (reset) begin
      m_state = 0; m_s = 0; m_c = 0; m_frac = 0; m_pb = 0;
      m_fcw = 'h100; m_rdy = 1'b1;
      sb.delete();
    end else begin
      case (m_state)
        0: if (bus.start) m_state = 1;
        1: begin
          adv = 1'b1;
          if (bus.stop) m_state = 2;
        end
        default: if (!bus.stop) begin
          if (bus.clear) begin
            m_state = 0; m_s = 0; m_c = 0; m_frac = 0; m_pb = 0;
          end else if (bus.start) m_state = 1;
          else if (bus.step) adv = 1'b1;
        end
      endcase
      if (adv) begin
        m_frac = m_frac + (m_fcw % 256);
        cy     = m_frac / 256;
        m_frac = m_frac % 256;
        inc    = ((m_fcw / 256) > 65) ? 65 : (m_fcw / 256);
        inc    = inc + cy;
        m_s    = m_s + inc;
        if (m_s >= 66) begin
          m_s = m_s - 66;
          m_c = (m_c + 1) % 64;
        end
        m_pb = (m_pb + inc) % 4096;
        sb.push_back(m_obs(inj));
      end
      if (bus.fcw_valid && m_rdy) begin
        m_fcw = int'(bus.fcw);
        m_rdy = 1'b0;
      end else begin
        m_rdy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, adv);
    chk("fcw_ready", bus.fcw_ready, m_rdy);
    if (bus.out_valid && sb.size() > 0) e = sb.pop_front();
    else                                e = m_obs(inj);
    chk("count_coarse", bus.count_coarse, e.cc);
    chk("count_coarse_del", bus.count_coarse_del, e.cd);
    chk("count_fine", bus.count_fine, e.fine);
    chk("phase_bin", bus.phase_bin, e.pb);
  endtask

  task automatic idle_cmds();
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.clear = 1'b0;
    bus.fcw_valid = 1'b0; bus.inject_stale = 1'b0;
  endtask

  task automatic do_reset();
    idle_cmds();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [14:0] v);
    bus.fcw = v;
    bus.fcw_valid = 1'b1;
    tick();
    bus.fcw_valid = 1'b0;
  endtask

  // start from IDLE/HOLD, then n advances with stop on the last one.
  task automatic run_adv(input int n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.stop = (i == n - 1);
      tick();
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    vt[0] = '{15'h0100, 66,   12'd66,  6'h01, 33'h0AAAAAAAA};
    vt[1] = '{15'h0100, 33,   12'd33,  6'h00, 33'h155555555};
    vt[2] = '{15'h0080, 10,   12'd5,   6'h00, 33'h0AAAAAAB5};
    vt[3] = '{15'h7F00, 3,    12'd195, 6'h03, 33'h16AAAAAAA};
    vt[4] = '{15'h4180, 2,    12'd131, 6'h01, 33'h1AAAAAAAA};
    vt[5] = '{15'h0100, 4096, 12'd0,   6'h21, 33'h0AAAAAAA5};
    vt[6] = '{15'h0100, 4224, 12'd128, 6'h00, 33'h0AAAAAAAA};

    bus.fcw = 15'h0100;
    do_reset();
    chk("rst_fine", bus.count_fine, 33'h0AAAAAAAA);
    chk("rst_cc", bus.count_coarse, 6'h00);
    chk("rst_cd", bus.count_coarse_del, 6'h00);
    chk("rst_pb", bus.phase_bin, 12'd0);
    chk("rst_rdy", bus.fcw_ready, 1'b1);
    chk("rst_vld", bus.out_valid, 1'b0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      load(vt[k].fcw);
      run_adv(vt[k].nadv);
      chk($sformatf("vec%0d_pb", k), bus.phase_bin, vt[k].pb);
      chk($sformatf("vec%0d_cd", k), bus.count_coarse_del, vt[k].cd);
      chk($sformatf("vec%0d_fine", k), bus.count_fine, vt[k].fine);
    end

    // Stale injection: s=5, c=1 is inside the window; s=40 is outside.
    do_reset();
    run_adv(71);
    bus.inject_stale = 1'b1;
    tick();
    chk("stale_in_cc", bus.count_coarse, 6'h00);
    chk("stale_in_cd", bus.count_coarse_del, 6'h01);
    bus.step = 1'b1;
    repeat (35) tick();
    bus.step = 1'b0;
    chk("stale_out_cc", bus.count_coarse, 6'h01);
    chk("stale_out_cd", bus.count_coarse_del, 6'h01);
    chk("stale_out_pb", bus.phase_bin, 12'd106);
    bus.inject_stale = 1'b0;

    // HOLD: idle cycles do not advance, three single steps, then clear.
    tick();
    tick();
    chk("hold_pb", bus.phase_bin, 12'd106);
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      tick();
    end
    chk("step3_pb", bus.phase_bin, 12'd109);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_pb", bus.phase_bin, 12'd0);
    chk("clear_fine", bus.count_fine, 33'h0AAAAAAAA);
    chk("clear_cd", bus.count_coarse_del, 6'h00);
    run_adv(1);
    chk("after_clear_pb", bus.phase_bin, 12'd1);

    // Back-to-back fcw offers in RUN, then reset mid-RUN with an offer pending.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.fcw = 15'h0200;
    bus.fcw_valid = 1'b1;
    tick();
    chk("b2b_rdy_low", bus.fcw_ready, 1'b0);
    bus.fcw = 15'h0300;
    tick();
    chk("b2b_rdy_high", bus.fcw_ready, 1'b1);
    bus.fcw_valid = 1'b0;
    tick();
    chk("b2b_pb", bus.phase_bin, 12'd6);
    reset = 1'b1;
    bus.fcw_valid = 1'b1;
    tick();
    reset = 1'b0;
    bus.fcw_valid = 1'b0;
    chk("midrst_fine", bus.count_fine, 33'h0AAAAAAAA);
    chk("midrst_cc", bus.count_coarse, 6'h00);
    chk("midrst_pb", bus.phase_bin, 12'd0);
    chk("midrst_vld", bus.out_valid, 1'b0);
    chk("midrst_rdy", bus.fcw_ready, 1'b1);
    run_adv(3);
    chk("midrst_fcw_pb", bus.phase_bin, 12'd3);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
